// File: rtl/matrix_vector_mult_3x3.sv
// matrix_vector_mult_3x3: buffers a row-major 3x3 element stream and multiplies it by a local 3-vector in signed fixed point
// Latency: first result 3 cycles, last result 9 cycles after the final element is accepted; done follows one cycle later
// Backpressure: m_ready is high only while loading; elements offered at other times are dropped and flagged on overrun
module matrix_vector_mult_3x3 #(
  parameter int M          = 3,
  parameter int P          = 3,
  parameter int DATA_WIDTH = 32,
  parameter int FRAC_BITS  = 16
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic signed [DATA_WIDTH-1:0] m_in,
  input  logic                         m_valid,
  output logic                         m_ready,
  input  logic signed [DATA_WIDTH-1:0] v_in,
  input  logic [1:0]                   v_addr,
  input  logic                         v_wen,
  output logic signed [DATA_WIDTH-1:0] y_out,
  output logic                         y_valid,
  output logic [1:0]                   y_idx,
  output logic                         done,
  output logic                         busy,
  output logic                         sat,
  output logic                         overrun
);

  localparam int N_EL = M * P;
  localparam int PW   = 2 * DATA_WIDTH;
  localparam int AW   = 2 * DATA_WIDTH + 2;

  localparam logic [3:0] LD_LAST  = 4'(N_EL - 1);
  localparam logic [1:0] COL_LAST = 2'(P - 1);
  localparam logic [1:0] ROW_LAST = 2'(M - 1);

  // Result clamp limits, sign-extended to accumulator width
  localparam logic signed [AW-1:0] SAT_MAX = {{(AW-DATA_WIDTH+1){1'b0}}, {(DATA_WIDTH-1){1'b1}}};
  localparam logic signed [AW-1:0] SAT_MIN = {{(AW-DATA_WIDTH+1){1'b1}}, {(DATA_WIDTH-1){1'b0}}};

  typedef enum logic [1:0] {
    S_LOAD = 2'd0,
    S_MAC  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t state, state_nxt;

  logic signed [DATA_WIDTH-1:0] mat [0:8];
  logic signed [DATA_WIDTH-1:0] vec [0:2];

  logic [3:0]           ld_cnt;
  logic [1:0]           row;
  logic [1:0]           col;
  logic signed [AW-1:0] acc;

  logic                  accept;
  logic                  last_load;
  logic                  last_col;
  logic [3:0]            mac_idx;
  logic signed [PW-1:0]  prod;
  logic signed [AW-1:0]  sum;
  logic signed [AW-1:0]  shifted;
  logic [DATA_WIDTH-1:0] res;
  logic                  clamp;

  assign m_ready   = (state == S_LOAD);
  assign busy      = (state == S_MAC) || (state == S_DONE);
  assign accept    = m_valid && m_ready;
  assign last_load = accept && (ld_cnt == LD_LAST);
  assign last_col  = (col == COL_LAST);

  // Full-precision product of the current matrix element and vector element
  assign mac_idx = 4'(row) * 4'(P) + 4'(col);
  assign prod    = PW'(mat[mac_idx]) * PW'(vec[col]);
  assign sum     = acc + AW'(prod);
  assign shifted = sum >>> FRAC_BITS;

  // Truncate the row sum to the output format and clamp to the representable range
  always_comb begin
    res   = shifted[DATA_WIDTH-1:0];
    clamp = 1'b0;
    if (shifted > SAT_MAX) begin
      res   = SAT_MAX[DATA_WIDTH-1:0];
      clamp = 1'b1;
    end else if (shifted < SAT_MIN) begin
      res   = SAT_MIN[DATA_WIDTH-1:0];
      clamp = 1'b1;
    end
  end

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_LOAD;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic; S_DONE lasts two cycles so done pulses before loading reopens
  always_comb begin
    state_nxt = state;
    case (state)
      S_LOAD: if (last_load) state_nxt = S_MAC;
      S_MAC:  if (last_col && (row == ROW_LAST)) state_nxt = S_DONE;
      S_DONE: if (done) state_nxt = S_LOAD;
      default: state_nxt = S_LOAD;
    endcase
  end

  // Element and vector storage; contents survive reset
  always_ff @(posedge clk) begin
    if (accept) begin
      mat[ld_cnt] <= m_in;
    end
    if (v_wen && !busy && (v_addr < 2'(P))) begin
      vec[v_addr] <= v_in;
    end
  end

  // Load counter, MAC sequencing and registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      ld_cnt  <= '0;
      row     <= '0;
      col     <= '0;
      acc     <= '0;
      y_out   <= '0;
      y_valid <= 1'b0;
      y_idx   <= '0;
      done    <= 1'b0;
      sat     <= 1'b0;
      overrun <= 1'b0;
    end else begin
      y_valid <= 1'b0;
      done    <= 1'b0;
      overrun <= m_valid && !m_ready;
      case (state)
        S_LOAD: begin
          if (accept) begin
            if (ld_cnt == LD_LAST) begin
              ld_cnt <= '0;
              sat    <= 1'b0;
              acc    <= '0;
              row    <= '0;
              col    <= '0;
            end else begin
              ld_cnt <= ld_cnt + 4'd1;
            end
          end
        end
        S_MAC: begin
          if (last_col) begin
            y_out   <= res;
            y_valid <= 1'b1;
            y_idx   <= row;
            acc     <= '0;
            col     <= '0;
            if (clamp) sat <= 1'b1;
            if (row != ROW_LAST) row <= row + 2'd1;
          end else begin
            acc <= sum;
            col <= col + 2'd1;
          end
        end
        S_DONE: begin
          done <= !done;
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_matrix_vector_mult_3x3.sv
// tb_matrix_vector_mult_3x3: directed and randomized frames checked against an arithmetic reference model
// Latency: checks result timing relative to the edge accepting the last element
// Backpressure: the element source honours m_ready except where drops are deliberately injected
module tb_matrix_vector_mult_3x3;

  logic        clk;
  logic        rst;
  logic [31:0] m_in;
  logic        m_valid;
  logic        m_ready;
  logic [31:0] v_in;
  logic [1:0]  v_addr;
  logic        v_wen;
  logic [31:0] y_out;
  logic        y_valid;
  logic [1:0]  y_idx;
  logic        done;
  logic        busy;
  logic        sat;
  logic        overrun;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  logic signed [31:0] mat_s [9];
  logic signed [31:0] vec_s [3];

  logic [31:0] ys [$];
  logic [1:0]  yi [$];
  int          yc [$];
  int done_cnt = 0;
  int done_cyc = -1;
  int ovr_cnt  = 0;
  int e_stamp  = 0;
  int o0;
  int d0;

  matrix_vector_mult_3x3 dut (
    .clk     (clk),
    .rst     (rst),
    .m_in    (m_in),
    .m_valid (m_valid),
    .m_ready (m_ready),
    .v_in    (v_in),
    .v_addr  (v_addr),
    .v_wen   (v_wen),
    .y_out   (y_out),
    .y_valid (y_valid),
    .y_idx   (y_idx),
    .done    (done),
    .busy    (busy),
    .sat     (sat),
    .overrun (overrun)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Advance to the next falling edge and record any output events
  task automatic tick();
    @(negedge clk);
    if (y_valid) begin
      ys.push_back(y_out);
      yi.push_back(y_idx);
      yc.push_back(cyc);
    end
    if (done) begin
      done_cnt++;
      done_cyc = cyc;
    end
    if (overrun) ovr_cnt++;
  endtask

  // Reference: exact row dot product, floor-shifted, clamped to 32-bit signed
  function automatic logic [31:0] ref_y(input int r, output bit clamp);
    logic signed [127:0] s, a, b, hi, lo;
    s  = '0;
    hi = 128'sh7FFFFFFF;
    lo = -hi - 128'sd1;
    for (int c = 0; c < 3; c++) begin
      a = mat_s[r*3+c];
      b = vec_s[c];
      s = s + a * b;
    end
    s = s >>> 16;
    clamp = 1'b0;
    if (s > hi) begin
      clamp = 1'b1;
      return 32'h7FFFFFFF;
    end
    if (s < lo) begin
      clamp = 1'b1;
      return 32'h80000000;
    end
    return s[31:0];
  endfunction

  task automatic rand_mat();
    logic [31:0] r;
    for (int k = 0; k < 9; k++) begin
      r = $urandom;
      mat_s[k] = $signed(r) >>> $urandom_range(8, 16);
    end
  endtask

  task automatic rand_vec();
    logic [31:0] r;
    for (int k = 0; k < 3; k++) begin
      r = $urandom;
      vec_s[k] = $signed(r) >>> $urandom_range(8, 16);
    end
  endtask

  // Write the vector, then a stray write to index 3 that must be ignored
  task automatic write_vec();
    for (int i = 0; i < 3; i++) begin
      v_wen  = 1'b1;
      v_addr = 2'(i);
      v_in   = vec_s[i];
      tick();
    end
    v_addr = 2'd3;
    v_in   = $urandom;
    tick();
    v_wen = 1'b0;
  endtask

  // Stream nine elements honouring m_ready; optionally write vec[2] alongside the last one
  task automatic load_mat(input bit late_v, input logic [31:0] late_val);
    int k = 0;
    int guard = 0;
    ys.delete();
    yi.delete();
    yc.delete();
    done_cyc = -1;
    while (k < 9 && guard < 60) begin
      v_wen = 1'b0;
      if (m_ready) begin
        m_valid = 1'b1;
        m_in    = mat_s[k];
        if (k == 8 && late_v) begin
          v_wen    = 1'b1;
          v_addr   = 2'd2;
          v_in     = late_val;
          vec_s[2] = late_val;
        end
        k++;
      end else begin
        m_valid = 1'b0;
      end
      tick();
      guard++;
    end
    m_valid = 1'b0;
    v_wen   = 1'b0;
    e_stamp = cyc;
    chk("load_all", k, 9);
    chk("busy_after_load", busy, 1);
    chk("sat_clear_on_load", sat, 0);
  endtask

  // Wait for done; optionally offer elements and vector writes during the busy window
  task automatic wait_done(input int inject);
    int n = 0;
    int d_start = done_cnt;
    while (done_cnt == d_start && n < 30) begin
      if (n < inject) begin
        m_valid = 1'b1;
        m_in    = $urandom;
        v_wen   = 1'b1;
        v_addr  = 2'(n % 3);
        v_in    = $urandom;
      end else begin
        m_valid = 1'b0;
        v_wen   = 1'b0;
      end
      tick();
      n++;
    end
    m_valid = 1'b0;
    v_wen   = 1'b0;
    chk("done_seen", done_cnt - d_start, 1);
    chk("ready_low_in_done", m_ready, 0);
    tick();
    chk("ready_back", m_ready, 1);
  endtask

  task automatic check_frame(input string tag);
    bit clamp;
    bit any_sat = 1'b0;
    logic [31:0] e;
    chk({tag, "_count"}, ys.size(), 3);
    for (int i = 0; i < 3; i++) begin
      e = ref_y(i, clamp);
      any_sat |= clamp;
      chk({tag, "_y"},     (i < ys.size()) ? {32'd0, ys[i]} : 64'hx, {32'd0, e});
      chk({tag, "_idx"},   (i < yi.size()) ? {62'd0, yi[i]} : 64'hx, i);
      chk({tag, "_ytime"}, (i < yc.size()) ? yc[i] : -1, e_stamp + 3 * (i + 1));
    end
    chk({tag, "_dtime"}, done_cyc, e_stamp + 10);
    chk({tag, "_sat"}, sat, any_sat);
  endtask

  task automatic chk_consts(input string tag, input logic [31:0] e0, input logic [31:0] e1, input logic [31:0] e2);
    logic [31:0] ex [3];
    ex[0] = e0;
    ex[1] = e1;
    ex[2] = e2;
    for (int i = 0; i < 3; i++) begin
      chk(tag, (i < ys.size()) ? {32'd0, ys[i]} : 64'hx, {32'd0, ex[i]});
    end
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_y_out"},   y_out,   0);
    chk({tag, "_y_valid"}, y_valid, 0);
    chk({tag, "_y_idx"},   y_idx,   0);
    chk({tag, "_done"},    done,    0);
    chk({tag, "_sat"},     sat,     0);
    chk({tag, "_overrun"}, overrun, 0);
    chk({tag, "_busy"},    busy,    0);
    chk({tag, "_m_ready"}, m_ready, 1);
  endtask

  initial begin
    rst     = 1'b1;
    m_valid = 1'b0;
    m_in    = '0;
    v_in    = '0;
    v_addr  = '0;
    v_wen   = 1'b0;
    repeat (3) tick();
    chk_reset_outputs("reset");
    rst = 1'b0;
    tick();

    // Identity matrix with V = (1.0, 2.0, -3.0)
    for (int k = 0; k < 9; k++) mat_s[k] = (k % 4 == 0) ? 32'sh00010000 : 32'sh0;
    vec_s[0] = 32'sh00010000;
    vec_s[1] = 32'sh00020000;
    vec_s[2] = 32'shFFFD0000;
    write_vec();
    load_mat(1'b0, 32'd0);
    wait_done(0);
    check_frame("ident");
    chk_consts("ident_const", 32'h00010000, 32'h00020000, 32'hFFFD0000);

    // Rows (1,2,3),(4,5,6),(7,8,9) with V = (1, 0.5, -1): -1.0, 0.5, 2.0
    for (int k = 0; k < 9; k++) mat_s[k] = (k + 1) <<< 16;
    vec_s[0] = 32'sh00010000;
    vec_s[1] = 32'sh00008000;
    vec_s[2] = 32'shFFFF0000;
    write_vec();
    load_mat(1'b0, 32'd0);
    wait_done(0);
    check_frame("general");
    chk_consts("general_const", 32'hFFFF0000, 32'h00008000, 32'h00020000);

    // Positive saturation on every row
    for (int k = 0; k < 9; k++) mat_s[k] = 32'sh7FFF0000;
    for (int k = 0; k < 3; k++) vec_s[k] = 32'sh7FFF0000;
    write_vec();
    load_mat(1'b0, 32'd0);
    wait_done(0);
    check_frame("satur");
    chk_consts("satur_const", 32'h7FFFFFFF, 32'h7FFFFFFF, 32'h7FFFFFFF);
    chk("satur_flag", sat, 1);

    // Identity frame afterwards clears the sticky flag
    for (int k = 0; k < 9; k++) mat_s[k] = (k % 4 == 0) ? 32'sh00010000 : 32'sh0;
    vec_s[0] = 32'sh00010000;
    vec_s[1] = 32'sh00020000;
    vec_s[2] = 32'shFFFD0000;
    write_vec();
    load_mat(1'b0, 32'd0);
    wait_done(0);
    check_frame("sat_clear");
    chk("sat_clear_flag", sat, 0);

    // Elements and vector writes offered while busy are dropped
    rand_mat();
    rand_vec();
    write_vec();
    load_mat(1'b0, 32'd0);
    o0 = ovr_cnt;
    wait_done(4);
    chk("overrun_pulses", ovr_cnt - o0, 4);
    check_frame("overrun");

    // Reset asserted for the edge E+4 abandons the frame
    rand_mat();
    load_mat(1'b0, 32'd0);
    repeat (3) tick();
    rst = 1'b1;
    tick();
    chk_reset_outputs("midreset");
    rst = 1'b0;
    d0 = done_cnt;
    repeat (20) tick();
    chk("midreset_results", ys.size(), 1);
    chk("midreset_no_done", done_cnt - d0, 0);

    // Fresh load after reset, with vec[2] written alongside the final element
    rand_mat();
    load_mat(1'b1, $urandom >> $urandom_range(8, 16));
    wait_done(0);
    check_frame("post_reset");

    // Back-to-back frames: next burst starts right after done
    o0 = ovr_cnt;
    rand_mat();
    load_mat(1'b0, 32'd0);
    wait_done(0);
    check_frame("b2b_a");
    rand_mat();
    load_mat(1'b0, 32'd0);
    wait_done(0);
    check_frame("b2b_b");
    chk("b2b_no_overrun", ovr_cnt - o0, 0);

    // Further randomized frames
    for (int t = 0; t < 3; t++) begin
      rand_mat();
      rand_vec();
      write_vec();
      load_mat(1'b0, 32'd0);
      wait_done(0);
      check_frame("random");
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
